// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage MIPS core: shadow EX/MEM/WB tracking, stall/bubble/flush and forwarding selects.
// Optional macro FORWARD_EN: enables EX/MEM and MEM/WB forwarding; when undefined the core interlocks on every RAW.
module hazard_unit #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic [4:0]             id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_memread,
    input  logic                   id_ifflush,
    output logic                   stall,
    output logic                   bubble,
    output logic                   flush_if,
    output logic [1:0]             forward_a,
    output logic [1:0]             forward_b,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
    } shadow_t;

    localparam shadow_t BUBBLE = '0;

    logic                   vld_p0, vld_p1, vld_p2;
    shadow_t                ex_p0, mem_p1, wb_p2;
    shadow_t                id_entry;
    logic [STALL_CNT_W-1:0] stall_count_q;
    logic                   stall_c;
    logic                   unused_shadow;

    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic reads_dst(input shadow_t p, input logic [4:0] rs, input logic [4:0] rt);
        return reg_hit(p.rd, rs) || reg_hit(p.rd, rt);
    endfunction

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

`ifdef FORWARD_EN
    // MEM is the younger producer, so it takes priority over WB.
    function automatic logic [1:0] fwd_sel(input shadow_t mem, input shadow_t wb, input logic [4:0] src);
        if (mem.regwrite && reg_hit(mem.rd, src)) begin
            return 2'b10;
        end
        if (wb.regwrite && reg_hit(wb.rd, src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction
`endif

    always_comb begin
        id_entry          = BUBBLE;
        id_entry.regwrite = id_regwrite;
        id_entry.memread  = id_memread;
        id_entry.rd       = id_rd;
        id_entry.rs       = id_rs;
        id_entry.rt       = id_rt;
    end

    always_comb begin
        stall_c   = 1'b0;
        forward_a = 2'b00;
        forward_b = 2'b00;
`ifdef FORWARD_EN
        stall_c   = id_valid && vld_p0 && ex_p0.memread && reads_dst(ex_p0, id_rs, id_rt);
        forward_a = fwd_sel(mem_p1, wb_p2, ex_p0.rs);
        forward_b = fwd_sel(mem_p1, wb_p2, ex_p0.rt);
`else
        // Without forwarding, any pending write in EX or MEM blocks the reader; WB is write-through.
        stall_c = id_valid &&
                  ((vld_p0 && ex_p0.regwrite  && reads_dst(ex_p0,  id_rs, id_rt)) ||
                   (vld_p1 && mem_p1.regwrite && reads_dst(mem_p1, id_rs, id_rt)));
`endif
    end

    assign stall       = stall_c;
    assign bubble      = stall_c;
    assign flush_if    = id_valid & id_ifflush & ~stall_c;
    assign stall_count = stall_count_q;

    // Fields retained in the shadow copy that the selected build does not consume.
    assign unused_shadow = ^{vld_p1, vld_p2, ex_p0, mem_p1, wb_p2};

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0        <= 1'b0;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            ex_p0         <= BUBBLE;
            mem_p1        <= BUBBLE;
            wb_p2         <= BUBBLE;
            stall_count_q <= '0;
        end else begin
            // ID -> EX boundary: a stalled or empty ID slot enters EX as a bubble.
            if (id_valid && !stall_c) begin
                vld_p0 <= 1'b1;
                ex_p0  <= id_entry;
            end else begin
                vld_p0 <= 1'b0;
                ex_p0  <= BUBBLE;
            end
            // EX -> MEM boundary
            vld_p1 <= vld_p0;
            mem_p1 <= ex_p0;
            // MEM -> WB boundary
            vld_p2 <= vld_p1;
            wb_p2  <= mem_p1;
            if (stall_c) begin
                stall_count_q <= sat_inc(stall_count_q);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Randomised and directed bench for hazard_unit against an instruction-history reference model.
module tb_hazard_unit;

    localparam int CW = 4;
    localparam int OW = 7 + CW;
`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          id_regwrite, id_memread, id_ifflush;
    logic          stall, bubble, flush_if;
    logic [1:0]    forward_a, forward_b;
    logic [CW-1:0] stall_count;

    hazard_unit #(.STALL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ifflush(id_ifflush),
        .stall(stall), .bubble(bubble), .flush_if(flush_if),
        .forward_a(forward_a), .forward_b(forward_b), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit       rw;
        bit       mr;
        bit       ff;
        bit [4:0] rd;
        bit [4:0] rs;
        bit [4:0] rt;
    } instr_t;

    // hist[2] is the instruction in EX, hist[1] in MEM, hist[0] in WB.
    instr_t hist[$];
    instr_t cur;
    int     m_cnt;
    int     checks = 0;
    int     errors = 0;

    function automatic instr_t mk(bit v, bit [4:0] rd, bit [4:0] rs, bit [4:0] rt, bit rw, bit mr, bit ff);
        instr_t i;
        i.v = v; i.rd = rd; i.rs = rs; i.rt = rt; i.rw = rw; i.mr = mr; i.ff = ff;
        return i;
    endfunction

    function automatic instr_t nop();
        return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic bit writes(instr_t p, bit [4:0] r);
        return p.rw && (r != 5'd0) && (p.rd == r);
    endfunction

    // A reader in ID must wait while a producer whose result it cannot obtain yet is 1 or 2 slots ahead.
    function automatic bit m_stall();
        if (!cur.v) return 1'b0;
        if (FWD) return hist[2].v && hist[2].mr && (hist[2].rd != 5'd0) &&
                        (hist[2].rd == cur.rs || hist[2].rd == cur.rt);
        for (int d = 1; d <= 2; d++) begin
            if (hist[3-d].v && (writes(hist[3-d], cur.rs) || writes(hist[3-d], cur.rt))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit [1:0] m_fwd(bit [4:0] r);
        if (!FWD) return 2'b00;
        if (writes(hist[1], r)) return 2'b10;
        if (writes(hist[0], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [OW-1:0] m_out();
        bit s;
        s = m_stall();
        return {s, s, cur.v & cur.ff & ~s, m_fwd(hist[2].rs), m_fwd(hist[2].rt), CW'(m_cnt)};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {stall, bubble, flush_if, forward_a, forward_b, stall_count};
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(nop());
        m_cnt = 0;
    endtask

    task automatic present(instr_t i);
        cur         = i;
        id_valid    = i.v;
        id_rd       = i.rd;
        id_rs       = i.rs;
        id_rt       = i.rt;
        id_regwrite = i.rw;
        id_memread  = i.mr;
        id_ifflush  = i.ff;
        #3;
    endtask

    task automatic tick();
        bit s;
        s = m_stall();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (s && m_cnt < (2**CW) - 1) m_cnt++;
            hist.push_back((cur.v && !s) ? cur : nop());
            hist.delete(0);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        present(nop());
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [OW-1:0] e;
        rst = 1'b1;
        present(nop());
        tick();
        for (int k = 0; k < 2; k++) begin
            present(k == 0 ? nop() : mk(1'b1, 5'd0, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1));
            e = m_out();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b, expected %b", k, obs(), e);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        instr_t prog[$];
        logic [OW-1:0] e;
        do_reset();
        prog.push_back(mk(1'b1, 5'd2, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0));
        prog.push_back(mk(1'b1, 5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 7; k++) begin
            present(prog.size() != 0 ? prog[0] : nop());
            e = m_out();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL load_use cycle %0d: got %b, expected %b", k, obs(), e);
            end
            if (!e[OW-1] && prog.size() != 0) prog.delete(0);
            tick();
        end
        present(nop());
        checks++;
        if (stall_count !== CW'(FWD ? 1 : 2)) begin
            errors++;
            $display("FAIL load_use_count: got %0d, expected %0d", stall_count, FWD ? 1 : 2);
        end
    endtask

    task automatic test_alu_forward();
        instr_t prog[$];
        logic [OW-1:0] e;
        int both10 = 0;
        do_reset();
        prog.push_back(mk(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0));
        prog.push_back(mk(1'b1, 5'd7, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 7; k++) begin
            present(prog.size() != 0 ? prog[0] : nop());
            e = m_out();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL alu_forward cycle %0d: got %b, expected %b", k, obs(), e);
            end
            if (forward_a == 2'b10 && forward_b == 2'b10) both10++;
            if (!e[OW-1] && prog.size() != 0) prog.delete(0);
            tick();
        end
        present(nop());
        checks++;
        if (stall_count !== CW'(FWD ? 0 : 2) || both10 != (FWD ? 1 : 0)) begin
            errors++;
            $display("FAIL alu_forward_summary: got count %0d fwd10 %0d, expected count %0d fwd10 %0d",
                     stall_count, both10, FWD ? 0 : 2, FWD ? 1 : 0);
        end
    endtask

    task automatic test_zero_reg();
        instr_t prog[$];
        logic [OW-1:0] e;
        do_reset();
        prog.push_back(mk(1'b1, 5'd0, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0));
        prog.push_back(mk(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 6; k++) begin
            present(prog.size() != 0 ? prog[0] : nop());
            e = m_out();
            checks++;
            if (obs() !== e || stall !== 1'b0 || forward_a !== 2'b00 || forward_b !== 2'b00) begin
                errors++;
                $display("FAIL zero_reg cycle %0d: got %b, expected %b", k, obs(), e);
            end
            if (!e[OW-1] && prog.size() != 0) prog.delete(0);
            tick();
        end
    endtask

    task automatic test_branch_stall();
        instr_t prog[$];
        logic [OW-1:0] e;
        int flush_cyc = -1;
        int flushes = 0;
        do_reset();
        prog.push_back(mk(1'b1, 5'd2, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0));
        prog.push_back(mk(1'b1, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1));
        for (int k = 0; k < 6; k++) begin
            present(prog.size() != 0 ? prog[0] : nop());
            e = m_out();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL branch_stall cycle %0d: got %b, expected %b", k, obs(), e);
            end
            if (flush_if === 1'b1) begin
                flushes++;
                if (flush_cyc < 0) flush_cyc = k;
            end
            if (!e[OW-1] && prog.size() != 0) prog.delete(0);
            tick();
        end
        checks++;
        if (flushes != 1 || flush_cyc != (FWD ? 2 : 3)) begin
            errors++;
            $display("FAIL branch_flush: got %0d flushes at cycle %0d, expected 1 at cycle %0d",
                     flushes, flush_cyc, FWD ? 2 : 3);
        end
    endtask

    task automatic test_reset_saturate();
        instr_t ld;
        logic [OW-1:0] e;
        logic [CW-1:0] ones = '1;
        int nst = 0;
        int k = 0;
        do_reset();
        present(mk(1'b1, 5'd2, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0));
        tick();
        present(mk(1'b1, 5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0));
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall: got %b, expected 1", stall);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        present(cur);
        e = m_out();
        checks++;
        if (obs() !== e || stall !== 1'b0 || stall_count !== '0) begin
            errors++;
            $display("FAIL post_reset: got %b, expected %b", obs(), e);
        end
        // A chain of loads, each using the previous result, keeps the stall line busy.
        ld = mk(1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0);
        while (nst < (2**CW) + 3 && k < 200) begin
            present(ld);
            e = m_out();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL saturate cycle %0d: got %b, expected %b", k, obs(), e);
            end
            if (e[OW-1]) nst++;
            tick();
            k++;
        end
        present(nop());
        checks++;
        if (stall_count !== ones || nst < (2**CW) + 3) begin
            errors++;
            $display("FAIL saturate_final: got count %0d after %0d stalls, expected %0d", stall_count, nst, ones);
        end
    endtask

    task automatic test_random();
        logic [OW-1:0] e;
        instr_t i;
        bit held = 1'b0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!held) begin
                i = mk(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) == 0));
            end
            present(i);
            e = m_out();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL random cycle %0d: got %b, expected %b", k, obs(), e);
            end
            held = e[OW-1] && !rst;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        test_reset();
        test_load_use();
        test_alu_forward();
        test_zero_reg();
        test_branch_stall();
        test_reset_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
